video_sync_gen: RTL

VIDEO_SYNC_GEN -- requirements
Module: video_sync_gen

---
 rtl/video_sync_if.sv | 25 ++
 rtl/video_sync_gen.sv | 106 ++++++++++
 2 files changed

// File: rtl/video_sync_if.sv
// Pixel-timing bundle between the sync generator and its consumers.
// pix_tick is a one-clk qualifier with no back-pressure: every clk with pix_tick=1 is one pixel step.
interface video_sync_if;
  logic       pix_tick;
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic       hsync_n;
  logic       vsync_n;
  logic       blank;
  logic       active;
  logic       border;
  logic       int_n;
  logic       frame_tick;
  logic       flash;

  modport master (
    input  pix_tick,
    output hcnt, vcnt, hsync_n, vsync_n, blank, active, border, int_n, frame_tick, flash
  );

  modport slave (
    output pix_tick,
    input  hcnt, vcnt, hsync_n, vsync_n, blank, active, border, int_n, frame_tick, flash
  );
endinterface

// File: rtl/video_sync_gen.sv
// Raster timing generator: pixel/line counters plus registered sync, blank,
// paper/border, frame interrupt and flash phase, all decoded from the same counter pair.
module video_sync_gen #(
  parameter int H_TOTAL  = 448,
  parameter int V_TOTAL  = 312,
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 192,
  parameter int HB_START = 320,
  parameter int HS_START = 336,
  parameter int HS_END   = 368,
  parameter int VB_START = 248,
  parameter int VB_END   = 256,
  parameter int VS_START = 248,
  parameter int VS_END   = 252,
  parameter int INT_LINE = 248,
  parameter int INT_LEN  = 64
) (
  input  logic         clk,
  input  logic         reset,
  video_sync_if.master vs
);
  localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
  localparam logic [8:0] HB_S     = 9'(HB_START);
  localparam logic [8:0] HS_S     = 9'(HS_START);
  localparam logic [8:0] HS_E     = 9'(HS_END);
  localparam logic [8:0] VB_S     = 9'(VB_START);
  localparam logic [8:0] VB_E     = 9'(VB_END);
  localparam logic [8:0] VS_S     = 9'(VS_START);
  localparam logic [8:0] VS_E     = 9'(VS_END);
  localparam logic [8:0] INT_L    = 9'(INT_LINE);
  localparam logic [8:0] INT_LAST = 9'(INT_LEN - 1);

  logic [8:0] h_nxt;
  logic [8:0] v_nxt;
  logic       h_wrap;
  logic       v_wrap;
  logic       frame_wrap;
  logic       int_start;
  logic       act_nxt;
  logic       blank_nxt;
  logic [8:0] int_cnt;
  logic [4:0] frame_cnt;

  // Flags are decoded from the next counter pair so they land in the same
  // register stage as the counters themselves.
  always_comb begin
    h_wrap     = (vs.hcnt == H_LAST);
    v_wrap     = (vs.vcnt == V_LAST);
    frame_wrap = h_wrap && v_wrap;
    h_nxt      = h_wrap ? 9'd0 : vs.hcnt + 9'd1;
    v_nxt      = vs.vcnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? 9'd0 : vs.vcnt + 9'd1;
    end
    int_start  = (h_nxt == 9'd0) && (v_nxt == INT_L);
    act_nxt    = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    blank_nxt  = (h_nxt >= HB_S) || ((v_nxt >= VB_S) && (v_nxt < VB_E));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs.hcnt       <= 9'd0;
      vs.vcnt       <= 9'd0;
      vs.hsync_n    <= 1'b1;
      vs.vsync_n    <= 1'b1;
      vs.blank      <= 1'b0;
      vs.active     <= 1'b1;
      vs.border     <= 1'b0;
      vs.int_n      <= 1'b1;
      vs.frame_tick <= 1'b0;
      int_cnt       <= 9'd0;
      frame_cnt     <= 5'd0;
    end else begin
      vs.frame_tick <= 1'b0;
      if (vs.pix_tick) begin
        vs.hcnt       <= h_nxt;
        vs.vcnt       <= v_nxt;
        vs.hsync_n    <= !((h_nxt >= HS_S) && (h_nxt < HS_E));
        vs.vsync_n    <= !((v_nxt >= VS_S) && (v_nxt < VS_E));
        vs.blank      <= blank_nxt;
        vs.active     <= act_nxt;
        vs.border     <= !act_nxt && !blank_nxt;
        vs.frame_tick <= frame_wrap;
        if (frame_wrap) begin
          frame_cnt <= frame_cnt + 5'd1;
        end
        // Width is counted in ticks, not hcnt, so the pulse may span any pixel range.
        if (int_start) begin
          vs.int_n <= 1'b0;
          int_cnt  <= INT_LAST;
        end else if (!vs.int_n) begin
          if (int_cnt == 9'd0) begin
            vs.int_n <= 1'b1;
          end else begin
            int_cnt <= int_cnt - 9'd1;
          end
        end
      end
    end
  end

  assign vs.flash = frame_cnt[4];
endmodule
